// File: rtl/ioports_host_arb.sv
// ioports_host_arb
//   Shares the byte-wide command bus of the 32-bit GPIO port block between
//   two 32-bit word requesters and a clear request. Each word transaction is
//   serialised into a command byte followed by four data bytes (MS first).
//   Reads use the ready/enout byte handshake and reassemble the word.
//
// Parameters:
//   LOAD_GAP   idle cycles (>= 1) after every io_load pulse
//   RD_TIMEOUT max cycles to wait for any single io_enout edge
//
// Ports:
//   clk, reset (async, active-low)
//   clr                          request a port-block RESET command
//   req0/1, we0/1, addr0/1, wdata0/1   requester transaction inputs
//   ack0/1, rdata0/1             completion pulse and read word
//   io_load, io_datain, io_ready       host side of the byte bus
//   io_enout, io_dataout         port-block side of the byte bus
//   busy, grant, err             status (grant one-hot, err sticky)
module ioports_host_arb #(
  parameter int unsigned LOAD_GAP   = 1,
  parameter int unsigned RD_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        req0,
  input  logic        we0,
  input  logic [3:0]  addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [3:0]  addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic        io_load,
  output logic [7:0]  io_datain,
  output logic        io_ready,
  input  logic        io_enout,
  input  logic [7:0]  io_dataout,
  output logic        busy,
  output logic [1:0]  grant,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_GAP, S_WBYTE, S_RREQ, S_RREL, S_DONE
  } state_t;

  localparam logic [2:0]  CMD_RESET = 3'd1;
  localparam logic [2:0]  CMD_WRITE = 3'd2;
  localparam logic [2:0]  CMD_READ  = 3'd3;
  localparam logic [15:0] GAP_LAST  = 16'(LOAD_GAP - 1);
  localparam logic [9:0]  TO_LAST   = 10'(RD_TIMEOUT - 1);

  state_t      state;
  logic        op_clr;
  logic        op_wr;
  logic        owner;      // 1 = requester 1 owns the transaction
  logic        last_gnt;   // requester granted most recently
  logic [31:0] wdata_q;
  logic [1:0]  bcnt;       // index of the current data byte (3 down to 0)
  logic        last_byte;  // byte 0 has been loaded; next GAP ends the write
  logic [15:0] gap_cnt;
  logic [9:0]  tcnt;
  logic [31:0] shreg;

  logic        pick1;
  logic        sel_we;
  logic [3:0]  sel_addr;
  logic [31:0] sel_wdata;

  // Round-robin: requester 1 wins when alone, or on a tie when 0 went last.
  always_comb begin
    pick1     = req1 && (!req0 || !last_gnt);
    sel_we    = pick1 ? we1    : we0;
    sel_addr  = pick1 ? addr1  : addr0;
    sel_wdata = pick1 ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_clr    <= 1'b0;
      op_wr     <= 1'b0;
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      wdata_q   <= '0;
      bcnt      <= '0;
      last_byte <= 1'b0;
      gap_cnt   <= '0;
      tcnt      <= '0;
      shreg     <= '0;
      io_load   <= 1'b0;
      io_datain <= '0;
      io_ready  <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
      grant     <= '0;
      err       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clr) begin
            op_clr    <= 1'b1;
            op_wr     <= 1'b0;
            io_load   <= 1'b1;
            io_datain <= {1'b0, CMD_RESET, 4'h0};
            busy      <= 1'b1;
            grant     <= '0;
            state     <= S_CMD;
          end else if (req0 || req1) begin
            op_clr    <= 1'b0;
            op_wr     <= sel_we;
            owner     <= pick1;
            last_gnt  <= pick1;
            wdata_q   <= sel_wdata;
            bcnt      <= 2'd3;
            last_byte <= 1'b0;
            io_load   <= 1'b1;
            io_datain <= {1'b0, (sel_we ? CMD_WRITE : CMD_READ), sel_addr};
            busy      <= 1'b1;
            grant     <= pick1 ? 2'b10 : 2'b01;
            state     <= S_CMD;
          end
        end

        S_CMD: begin
          io_load <= 1'b0;
          gap_cnt <= '0;
          state   <= S_GAP;
        end

        // Shared gap after every load; where it leads depends on the operation.
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (op_clr) begin
              busy  <= 1'b0;
              grant <= '0;
              state <= S_IDLE;
            end else if (op_wr) begin
              if (last_byte) begin
                if (owner) ack1 <= 1'b1;
                else       ack0 <= 1'b1;
                state <= S_DONE;
              end else begin
                io_load   <= 1'b1;
                io_datain <= wdata_q[{bcnt, 3'b000} +: 8];
                state     <= S_WBYTE;
              end
            end else begin
              io_ready <= 1'b1;
              tcnt     <= '0;
              state    <= S_RREQ;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        S_WBYTE: begin
          io_load <= 1'b0;
          gap_cnt <= '0;
          if (bcnt == 2'd0) last_byte <= 1'b1;
          else              bcnt      <= bcnt - 2'd1;
          state <= S_GAP;
        end

        S_RREQ: begin
          if (io_enout) begin
            shreg    <= {shreg[23:0], io_dataout};
            io_ready <= 1'b0;
            tcnt     <= '0;
            state    <= S_RREL;
          end else if (tcnt == TO_LAST) begin
            io_ready <= 1'b0;
            err      <= 1'b1;
            if (owner) begin ack1 <= 1'b1; rdata1 <= '0; end
            else       begin ack0 <= 1'b1; rdata0 <= '0; end
            state <= S_DONE;
          end else begin
            tcnt <= tcnt + 10'd1;
          end
        end

        S_RREL: begin
          if (!io_enout) begin
            tcnt <= '0;
            if (bcnt == 2'd0) begin
              if (owner) begin ack1 <= 1'b1; rdata1 <= shreg; end
              else       begin ack0 <= 1'b1; rdata0 <= shreg; end
              state <= S_DONE;
            end else begin
              bcnt     <= bcnt - 2'd1;
              io_ready <= 1'b1;
              state    <= S_RREQ;
            end
          end else if (tcnt == TO_LAST) begin
            err <= 1'b1;
            if (owner) begin ack1 <= 1'b1; rdata1 <= '0; end
            else       begin ack0 <= 1'b1; rdata0 <= '0; end
            state <= S_DONE;
          end else begin
            tcnt <= tcnt + 10'd1;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          grant <= '0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioports_host_arb.sv
module tb_ioports_host_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic        req0, we0, req1, we1;
  logic [3:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        io_load;
  logic [7:0]  io_datain;
  logic        io_ready;
  logic        io_enout = 1'b0;
  logic [7:0]  io_dataout = '0;
  logic        busy;
  logic [1:0]  grant;
  logic        err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ioports_host_arb #(.LOAD_GAP(1), .RD_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .io_load(io_load), .io_datain(io_datain), .io_ready(io_ready),
    .io_enout(io_enout), .io_dataout(io_dataout),
    .busy(busy), .grant(grant), .err(err)
  );

  // Minimal port-block model: decodes commands, stores written words,
  // answers read handshakes half a cycle after io_ready changes.
  logic [31:0] pb_out [16];
  int          pb_left = 0;
  int          pb_idx  = 0;
  logic [3:0]  pb_addr = '0;
  logic        stuck   = 1'b0;

  always @(negedge clk) begin
    logic [31:0] w;
    if (!reset) begin
      for (int i = 0; i < 16; i++) pb_out[i] = '0;
      pb_left  = 0;
      pb_idx   = 0;
      io_enout = 1'b0;
    end else begin
      if (io_load) begin
        if (pb_left == 0) begin
          case (io_datain[6:4])
            3'd1: for (int i = 0; i < 16; i++) pb_out[i] = '0;
            3'd2: begin pb_addr = io_datain[3:0]; pb_left = 4; end
            3'd3: begin pb_addr = io_datain[3:0]; pb_idx = 0; end
            default: ;
          endcase
        end else begin
          pb_out[pb_addr] = {pb_out[pb_addr][23:0], io_datain};
          pb_left = pb_left - 1;
        end
      end
      if (!stuck) begin
        if (io_ready && !io_enout) begin
          w = (pb_addr == 4'd15) ? 32'h2016_1700 : pb_out[pb_addr];
          w = w >> (8 * (3 - pb_idx));
          io_dataout = w[7:0];
          io_enout   = 1'b1;
          pb_idx     = pb_idx + 1;
        end else if (!io_ready && io_enout) begin
          io_enout = 1'b0;
        end
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    total++;
    if ({io_load, io_datain, io_ready, ack0, ack1, busy, grant, err} !== '0)
      $display("FAIL reset_ctrl: got %b required 0",
               {io_load, io_datain, io_ready, ack0, ack1, busy, grant, err});
    else passed++;
    total++;
    if ({rdata0, rdata1} !== '0)
      $display("FAIL reset_rdata: got %h required 0", {rdata0, rdata1});
    else passed++;
  endtask

  task automatic test_write;
    logic [7:0] wexp [5] = '{8'h23, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 32'hDEAD_BEEF;
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      total++;
      if (io_load !== ((c % 2 == 1) && c <= 9))
        $display("FAIL wr_load c%0d: got %b required %b", c, io_load, (c % 2 == 1) && c <= 9);
      else passed++;
      if (c <= 10) begin
        total++;
        if (io_datain !== wexp[(c - 1) / 2])
          $display("FAIL wr_byte c%0d: got %h required %h", c, io_datain, wexp[(c - 1) / 2]);
        else passed++;
      end
      total++;
      if (ack0 !== (c == 11))
        $display("FAIL wr_ack0 c%0d: got %b required %b", c, ack0, c == 11);
      else passed++;
      if (c == 1) begin
        total++;
        if ({busy, grant} !== 3'b101)
          $display("FAIL wr_grant: got %b required 101", {busy, grant});
        else passed++;
      end
    end
    req0 = 1'b0;
    next_cycle();
    total++;
    if ({busy, grant} !== 3'b000)
      $display("FAIL wr_idle: got %b required 000", {busy, grant});
    else passed++;
    total++;
    if (pb_out[3] !== 32'hDEAD_BEEF)
      $display("FAIL wr_out3: got %h required deadbeef", pb_out[3]);
    else passed++;
  endtask

  task automatic test_read;
    int  rises = 0;
    logic prev_ready = 1'b0;
    bit  seen = 0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd15;
    for (int c = 1; c <= 30 && !seen; c++) begin
      next_cycle();
      if (io_ready && !prev_ready) rises++;
      prev_ready = io_ready;
      if (c == 1) begin
        total++;
        if ({io_load, io_datain, grant} !== {1'b1, 8'h3F, 2'b10})
          $display("FAIL rd_cmd: got %b/%h/%b required 1/3f/10", io_load, io_datain, grant);
        else passed++;
      end
      if (c == 2 || c == 3) begin
        total++;
        if (io_ready !== (c == 3))
          $display("FAIL rd_ready c%0d: got %b required %b", c, io_ready, c == 3);
        else passed++;
      end
      if (ack1) begin
        seen = 1;
        req1 = 1'b0;
        total++;
        if (c !== 11) $display("FAIL rd_latency: got %0d required 11", c);
        else passed++;
        total++;
        if (rdata1 !== 32'h2016_1700)
          $display("FAIL rd_data: got %h required 20161700", rdata1);
        else passed++;
      end
    end
    total++;
    if (!seen) $display("FAIL rd_ack1: got none required pulse");
    else passed++;
    total++;
    if (rises !== 4) $display("FAIL rd_handshakes: got %0d required 4", rises);
    else passed++;
    req1 = 1'b0;
    next_cycle();
  endtask

  task automatic test_round_robin;
    logic [1:0] gexp;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 32'h1111_1111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd2; wdata1 = 32'h2222_2222;
    for (int t = 0; t < 4; t++) begin
      gexp = (t % 2 == 0) ? 2'b01 : 2'b10;
      for (int n = 0; n < 20 && !busy; n++) next_cycle();
      total++;
      if (grant !== gexp) $display("FAIL rr_grant t%0d: got %b required %b", t, grant, gexp);
      else passed++;
      for (int n = 0; n < 20 && !(ack0 || ack1); n++) next_cycle();
      total++;
      if ({ack1, ack0} !== gexp) $display("FAIL rr_ack t%0d: got %b required %b", t, {ack1, ack0}, gexp);
      else passed++;
      if (t == 3) begin req0 = 1'b0; req1 = 1'b0; end
      next_cycle();
    end
    total++;
    if ({pb_out[1], pb_out[2]} !== {32'h1111_1111, 32'h2222_2222})
      $display("FAIL rr_out: got %h %h required 11111111 22222222", pb_out[1], pb_out[2]);
    else passed++;
  endtask

  task automatic test_clear;
    clr = 1'b1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd5; wdata1 = 32'hCAFE_F00D;
    next_cycle();
    total++;
    if ({io_load, io_datain, busy, grant} !== {1'b1, 8'h10, 1'b1, 2'b00})
      $display("FAIL clr_cmd: got %b/%h/%b/%b required 1/10/1/00", io_load, io_datain, busy, grant);
    else passed++;
    clr = 1'b0;
    next_cycle();
    next_cycle();
    total++;
    if (busy !== 1'b0) $display("FAIL clr_busy_fall: got %b required 0", busy);
    else passed++;
    total++;
    if ((pb_out[1] | pb_out[2] | pb_out[3]) !== '0)
      $display("FAIL clr_ports: got %h %h %h required 0", pb_out[1], pb_out[2], pb_out[3]);
    else passed++;
    next_cycle();
    total++;
    if ({busy, grant, io_datain} !== {1'b1, 2'b10, 8'h25})
      $display("FAIL clr_then_req1: got %b/%b/%h required 1/10/25", busy, grant, io_datain);
    else passed++;
    for (int n = 0; n < 20 && !ack1; n++) next_cycle();
    req1 = 1'b0;
    total++;
    if (pb_out[5] !== 32'hCAFE_F00D) $display("FAIL clr_out5: got %h required cafef00d", pb_out[5]);
    else passed++;
    next_cycle();
  endtask

  task automatic test_timeout;
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
    for (int n = 0; n < 30 && !ack0; n++) next_cycle();
    req0 = 1'b0;
    total++;
    if ({ack0, rdata0} !== {1'b1, 32'hCAFE_F00D})
      $display("FAIL to_preread: got %b/%h required 1/cafef00d", ack0, rdata0);
    else passed++;
    next_cycle();
    stuck = 1'b1;
    req0 = 1'b1; addr0 = 4'd2;
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      if (c >= 3) begin
        total++;
        if (io_ready !== (c <= 10))
          $display("FAIL to_ready c%0d: got %b required %b", c, io_ready, c <= 10);
        else passed++;
      end
      if (c == 10) begin
        total++;
        if ({err, ack0} !== 2'b00) $display("FAIL to_early: got %b required 00", {err, ack0});
        else passed++;
      end
    end
    req0 = 1'b0;
    total++;
    if ({err, ack0, rdata0} !== {2'b11, 32'h0})
      $display("FAIL to_abort: got %b/%b/%h required 1/1/0", err, ack0, rdata0);
    else passed++;
    stuck = 1'b0;
    next_cycle();
    next_cycle();
    total++;
    if ({err, busy} !== 2'b10) $display("FAIL to_sticky: got %b required 10", {err, busy});
    else passed++;
  endtask

  task automatic test_reset_midwrite;
    bit seen = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 32'h0BAD_F00D;
    for (int c = 1; c <= 6; c++) next_cycle();
    req0 = 1'b0;
    #1 reset = 1'b0;
    #1;
    total++;
    if ({io_load, io_datain, io_ready, ack0, ack1, busy, grant, err, rdata0, rdata1} !== '0)
      $display("FAIL rst_async: got %b/%h/%b/%b/%b/%b/%b/%b/%h/%h required all 0",
               io_load, io_datain, io_ready, ack0, ack1, busy, grant, err, rdata0, rdata1);
    else passed++;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd4; wdata0 = 32'h1234_5678;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd6; wdata1 = 32'h9ABC_DEF0;
    next_cycle();
    total++;
    if (grant !== 2'b01) $display("FAIL rst_pointer: got %b required 01", grant);
    else passed++;
    for (int c = 2; c <= 11; c++) next_cycle();
    total++;
    if (ack0 !== 1'b1) $display("FAIL rst_wr_ack0: got %b required 1", ack0);
    else passed++;
    req0 = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      next_cycle();
      if (ack1) seen = 1;
    end
    req1 = 1'b0;
    total++;
    if (!seen) $display("FAIL rst_wr_ack1: got none required pulse");
    else passed++;
    total++;
    if ({pb_out[4], pb_out[6]} !== {32'h1234_5678, 32'h9ABC_DEF0})
      $display("FAIL rst_wr_out: got %h %h required 12345678 9abcdef0", pb_out[4], pb_out[6]);
    else passed++;
    next_cycle();
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    test_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    test_write();
    test_read();
    test_round_robin();
    test_clear();
    test_timeout();
    test_reset_midwrite();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ioports_host_arb.md
# ioports_host_arb

Arbiter and sequencer for the byte-wide command bus of the 32-bit general-purpose I/O port block. It shares that bus between two 32-bit word requesters (for example, the host link and an on-chip test master) plus a clear request. Each word transaction is serialised into the command-byte and data-byte protocol that the port block expects. For reads, the block runs the `ready`/`enout` byte handshake and reassembles the 32-bit word for the requester.

## Interface
- `LOAD_GAP`, default 1: idle cycles (minimum 1) after every `io_load` pulse.
- `RD_TIMEOUT`, default 1023: maximum cycles to wait for any single `io_enout` edge before a read is aborted.

Ports:
- `clk` in 1: master clock.
- `reset` in 1: reset is asynchronous and active-low.
- `clr` in 1: request a port-block RESET command (clears all output ports).
- `req0` in 1: requester 0 transaction request. `req1` is the same for requester 1.
- `we0` in 1: 1 = write, 0 = read. Same for `we1`.
- `addr0` in 4: port address. Same for `addr1`.
- `wdata0` in 32: write word. Same for `wdata1`.
- `ack0` out 1: one-cycle completion pulse. Same for `ack1`.
- `rdata0` out 32: read word, valid while `ackN` is high and held until the next read completes. Same for `rdata1`.
- `io_load` out 1: byte strobe to the port block.
- `io_datain` out 8: command or data byte.
- `io_ready` out 1: host ready to consume a read byte.
- `io_enout` in 1: port block byte valid.
- `io_dataout` in 8: read byte.
- `busy` out 1: a transaction is in progress.
- `grant` out 2: one-hot owner of the current transaction (clear transactions show 00).
- `err` out 1: sticky read-timeout flag; cleared only by `reset`.

## Operation
- **Command byte:** `{1'b0, cmd[2:0], addr[3:0]}`.
  - RESET = 0x10.
  - WRITE = 0x20 | addr.
  - READ = 0x30 | addr.
- **Readable addresses:** 0–7 and 15 (15 returns the hardware ID). Other addresses are forwarded unchanged; the returned value is undefined.
- **Arbitration** is evaluated only in IDLE:
  - `clr` has highest priority.
  - `req0` and `req1` are served round-robin. A last-grant pointer starts at 1 after reset, so requester 0 wins the first tie.
- `we`, `addr` and `wdata` are latched on the grant edge. The requester holds `req` until `ack`. `req` sampled high in IDLE the cycle after its own `ack` counts as a new request.
- **States:**
  - IDLE.
  - CMD: `io_load` = 1 with the command byte.
  - GAP: `LOAD_GAP` cycles, `io_load` = 0.
  - WBYTE: `io_load` = 1 with the data byte, MS byte first (byte 3 down to byte 0). Each WBYTE is followed by GAP.
  - RREQ: `io_ready` = 1 until `io_enout` = 1. On that edge, capture `io_dataout` into the shift register and move to RREL.
  - RREL: `io_ready` = 0 until `io_enout` = 0.
  - DONE: `ackN` = 1 for one cycle, then IDLE.
- **Sequences:**
  - Write: CMD, GAP, then 4 × (WBYTE, GAP), then DONE.
  - Read: CMD, GAP, then 4 × (RREQ, RREL), then DONE.
  - Clear: CMD, GAP, then IDLE, with no `ack`.
- The trailing GAP after the last write byte covers the port block's extra cycle after a write to port 15.
- `io_datain` holds its last value whenever `io_load` = 0.
- A 2-bit byte counter sequences the bytes. A 10-bit timeout counter runs in RREQ/RREL and reloads on each state entry.
- **Read timeout:** in RREQ or RREL, `RD_TIMEOUT` cycles without the awaited edge causes:
  - `io_ready` → 0 and `err` → 1.
  - `ackN` pulses with `rdata` = 0, then IDLE.
  - The port block may then be stuck, so system reset is required. Port block and this block must share the reset source.
- **Reset (asserted at any time, including mid-transaction):**
  - `io_load`, `io_datain`, `io_ready`, `ack0/1`, `rdata0/1`, `busy`, `grant` and `err` go to 0.
  - State goes to IDLE; the round-robin pointer goes to 1.
  - Any partial transaction is discarded with no `ack`.

## Timing
- Single clock; all outputs are registered.
- `busy` and `grant` rise on the grant edge and fall on the edge leaving DONE (or the clear's final GAP).
- Write latency with `LOAD_GAP` = 1: CMD is cycle 1, byte loads are on cycles 3, 5, 7 and 9, and `ack` is on cycle 11. General formula: `5·(1+LOAD_GAP)+1`.
- Read latency: CMD is cycle 1. `io_ready` rises on cycle `2+LOAD_GAP`. Each byte then costs 2 cycles plus the port-block response delay. `ack` follows the 4th RREL exit by one cycle.
- Simultaneous `clr` and `req` in IDLE: the clear runs first and the request is served next.
- `req` changes outside IDLE are ignored.

## Test plan
- `req0` write, addr 3, 0xDEADBEEF → `io_datain` sequence 0x23, DE, AD, BE, EF on cycles 1/3/5/7/9; `ack0` on cycle 11; port-block `out3` = 0xDEADBEEF.
- `req1` read, addr 15 → command 0x3F; four `ready`/`enout` handshakes; `rdata1` = 0x20161700 with `ack1`.
- `req0` and `req1` held continuously, both writes → grants alternate 0,1,0,1; no `ack` is ever lost.
- `clr` asserted together with `req1` → 0x10 issued first and all port outputs become 0; then the `req1` transaction runs.
- Read with `io_enout` stuck at 0, `RD_TIMEOUT` = 8 → `io_ready` low after 8 cycles, `err` = 1, `ack` with `rdata` = 0.
- `reset` asserted mid-write (after byte 2) → all outputs 0 asynchronously; after release, a new write completes correctly.
